coupled_cell_p: RTL and testbench

COUPLED_CELL_P -- requirements
Module: coupled_cell_p

---
 rtl/coupled_cell_p.sv | 160 ++++++++++++++++
 tb/tb_coupled_cell_p.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coupled_cell_p.sv
// Coupled oscillator cell: weight-controlled tunable delay on two oscillator paths,
// glitch-safe weight commit, and a windowed sin/din mismatch counter.
`timescale 1ns/1ps
module coupled_cell_p #(
  parameter int unsigned MAX_WEIGHT = 2,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned WW        = $clog2(2*MAX_WEIGHT+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             din,
  output logic             sout,
  output logic             dout,
  input  logic             wt_valid,
  input  logic [WW-1:0]    wt_data,
  output logic             wt_ready,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] mm_count
);

  localparam logic [WW-1:0] ZERO_W = WW'(MAX_WEIGHT);
  localparam logic [WW-1:0] TOP_W  = WW'(2*MAX_WEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    active_q, shadow_q;
  logic             wt_ready_q;
  logic [1:0]       sin_sync_q, din_sync_q;
  logic             sin_s, din_s, mm_s;
  logic [MAX_WEIGHT-1:0] hist_s_q, hist_d_q;
  logic             sout_q, dout_q, sout_d, dout_d;
  logic             c_pos, c_neg, slow_s, slow_d;
  logic [WW-1:0]    k, n_s, n_d;
  logic [CNT_W-1:0] win_q, win_d, mm_q, mm_d;
  logic             busy_q, busy_d, done_q, done_d;

  // Two-flop synchronizers for the mismatch and commit logic
  always_ff @(posedge clk) begin
    if (rst) begin
      sin_sync_q <= '0;
      din_sync_q <= '0;
    end else begin
      sin_sync_q <= {sin_sync_q[0], sin};
      din_sync_q <= {din_sync_q[0], din};
    end
  end

  assign sin_s = sin_sync_q[1];
  assign din_s = din_sync_q[1];
  assign mm_s  = sin_s ^ din_s;

  // Shadow weight only reaches the delay lines while both oscillators are low
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q   <= ZERO_W;
      shadow_q   <= ZERO_W;
      wt_ready_q <= 1'b1;
    end else if (!wt_ready_q) begin
      if (!sin_s && !din_s) begin
        active_q   <= shadow_q;
        wt_ready_q <= 1'b1;
      end
    end else if (wt_valid) begin
      shadow_q   <= (wt_data > TOP_W) ? TOP_W : wt_data;
      wt_ready_q <= 1'b0;
    end
  end

  // Slow-level selection and AND-of-taps delay: rising edges wait for every enabled tap
  always_comb begin
    c_pos  = active_q > ZERO_W;
    c_neg  = active_q < ZERO_W;
    k      = c_pos ? (active_q - ZERO_W) : (ZERO_W - active_q);
    slow_s = (c_pos && (sin ^ din)) || (c_neg && !(sin ^ din));
    slow_d = (c_pos && !(sout_q ^ dout_q)) || (c_neg && (sout_q ^ dout_q));
    n_s    = slow_s ? k : '0;
    n_d    = slow_d ? k : '0;
    sout_d = sin;
    dout_d = din;
    for (int i = 0; i < int'(MAX_WEIGHT); i++) begin
      if (WW'(i) < n_s) sout_d = sout_d & hist_s_q[i];
      if (WW'(i) < n_d) dout_d = dout_d & hist_d_q[i];
    end
  end

  // Oscillator delay stages carry no reset
  always_ff @(posedge clk) begin
    hist_s_q[0] <= sin;
    hist_d_q[0] <= din;
    for (int i = 1; i < int'(MAX_WEIGHT); i++) begin
      hist_s_q[i] <= hist_s_q[i-1];
      hist_d_q[i] <= hist_d_q[i-1];
    end
    sout_q <= sout_d;
    dout_q <= dout_d;
  end

  // Measurement FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      mm_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      mm_q    <= mm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Measurement FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (win_len == '0) ? S_DONE : S_COUNT;
      S_COUNT: if (win_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Measurement FSM: outputs and counters
  always_comb begin
    win_d  = win_q;
    mm_d   = mm_q;
    busy_d = (state_d == S_COUNT);
    done_d = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          win_d = win_len;
          mm_d  = '0;
        end
      end
      S_COUNT: begin
        win_d = win_q - CNT_W'(1);
        if (mm_s && (mm_q != '1)) mm_d = mm_q + CNT_W'(1);
      end
      default: begin
      end
    endcase
  end

  assign sout     = sout_q;
  assign dout     = dout_q;
  assign wt_ready = wt_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign mm_count = mm_q;

endmodule

// File: tb/tb_coupled_cell_p.sv
// Self-checking bench for coupled_cell_p against a cycle-level behavioural reference.
`timescale 1ns/1ps
module tb_coupled_cell_p;

  localparam int MW = 2;
  localparam int WW = $clog2(2*MW+1);
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, sin, din, wt_valid, start;
  logic [WW-1:0] wt_data;
  logic [CW-1:0] win_len;
  logic          sout, dout, wt_ready, busy, done;
  logic [CW-1:0] mm_count;

  logic          wt_valid4, start4;
  logic [WW-1:0] wt_data4;
  logic [3:0]    win_len4, mm4;
  logic          sout4, dout4, wt_ready4, busy4, done4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  coupled_cell_p #(.MAX_WEIGHT(MW), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .sin(sin), .din(din), .sout(sout), .dout(dout),
    .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
    .start(start), .win_len(win_len), .busy(busy), .done(done), .mm_count(mm_count)
  );

  coupled_cell_p #(.MAX_WEIGHT(MW), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .sin(sin), .din(din), .sout(sout4), .dout(dout4),
    .wt_valid(wt_valid4), .wt_data(wt_data4), .wt_ready(wt_ready4),
    .start(start4), .win_len(win_len4), .busy(busy4), .done(done4), .mm_count(mm4)
  );

  // Reference model: input histories, delayed synchronizer view, weight handshake, window
  bit sh[MW];
  bit dh[MW];
  bit m_sout, m_dout, ss1, ss2, ds1, ds2, m_ready, m_busy, m_done;
  int m_shadow, m_act, m_phase, m_left, m_mm;

  always @(posedge clk) begin
    int c, k, ns, nd;
    bit vs, vd, mm;
    c  = m_act - MW;
    k  = (c < 0) ? -c : c;
    ns = ((c > 0 && sin != din) || (c < 0 && sin == din)) ? k : 0;
    nd = ((c > 0 && m_sout == m_dout) || (c < 0 && m_sout != m_dout)) ? k : 0;
    vs = sin;
    vd = din;
    for (int j = 0; j < MW; j++) begin
      if (j < ns) vs = vs & sh[j];
      if (j < nd) vd = vd & dh[j];
    end
    for (int j = MW-1; j > 0; j--) begin
      sh[j] = sh[j-1];
      dh[j] = dh[j-1];
    end
    sh[0] = sin;
    dh[0] = din;
    m_sout = vs;
    m_dout = vd;
    if (rst) begin
      ss1 = 0; ss2 = 0; ds1 = 0; ds2 = 0;
      m_ready = 1; m_shadow = MW; m_act = MW;
      m_phase = 0; m_left = 0; m_mm = 0;
    end else begin
      mm = ss2 ^ ds2;
      if (!m_ready && !ss2 && !ds2) begin
        m_act = m_shadow;
        m_ready = 1;
      end else if (m_ready && wt_valid) begin
        m_shadow = (int'(wt_data) > 2*MW) ? 2*MW : int'(wt_data);
        m_ready = 0;
      end
      case (m_phase)
        0: if (start) begin
             m_mm = 0;
             if (win_len == 0) m_phase = 2;
             else begin m_phase = 1; m_left = int'(win_len); end
           end
        1: begin
             if (mm && m_mm < (2**CW - 1)) m_mm = m_mm + 1;
             m_left = m_left - 1;
             if (m_left == 0) m_phase = 2;
           end
        default: m_phase = 0;
      endcase
      ss2 = ss1; ss1 = sin; ds2 = ds1; ds1 = din;
    end
    m_busy = (m_phase == 1);
    m_done = (m_phase == 2);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit v;
    rst = 1; sin = 0; din = 0; wt_valid = 0; wt_data = '0; start = 0; win_len = '0;
    wt_valid4 = 0; wt_data4 = '0; start4 = 0; win_len4 = '0;
    repeat (4) cyc();
    rst = 0;
    n_chk++;
    if (wt_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || mm_count !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b busy=%b done=%b mm=%0d, want 1 0 0 0",
               wt_ready, busy, done, mm_count);
    end
    for (int i = 0; i < 10; i++) begin
      v = bit'(i % 2);
      sin = v; din = v;
      cyc();
      n_chk++;
      if (sout !== v || dout !== v || wt_ready !== 1'b1 || mm_count !== '0) begin
        n_fail++;
        $display("FAIL reset_follow[%0d]: sout=%b dout=%b ready=%b mm=%0d, want %b %b 1 0",
                 i, sout, dout, wt_ready, mm_count, v, v);
      end
    end
  endtask

  task automatic test_slow();
    logic [WW-1:0] codes [2];
    codes[0] = WW'(4);
    codes[1] = WW'(7);
    for (int w = 0; w < 2; w++) begin
      sin = 0; din = 0;
      repeat (3) cyc();
      wt_valid = 1; wt_data = codes[w];
      cyc();
      wt_valid = 0;
      n_chk++;
      if (wt_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL accept_ready[%0d]: got %b want 0", w, wt_ready);
      end
      cyc();
      n_chk++;
      if (wt_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL commit_ready[%0d]: got %b want 1", w, wt_ready);
      end
      repeat (3) cyc();
      sin = 1;
      for (int i = 1; i <= 3; i++) begin
        cyc();
        n_chk++;
        if (sout !== (i == 3)) begin
          n_fail++;
          $display("FAIL slow_rise[%0d] stage %0d: sout=%b want %b", w, i, sout, (i == 3));
        end
      end
      sin = 0; din = 0;
      repeat (3) cyc();
      sin = 1; din = 1;
      cyc();
      n_chk++;
      if (sout !== 1'b1 || dout !== m_dout) begin
        n_fail++;
        $display("FAIL fast_equal[%0d]: sout=%b dout=%b want 1 %b", w, sout, dout, m_dout);
      end
    end
  endtask

  task automatic test_random_osc();
    int guard;
    for (int it = 0; it < 8; it++) begin
      sin = 0; din = 0;
      repeat (3) cyc();
      wt_valid = 1; wt_data = WW'($urandom_range(0, 7));
      cyc();
      wt_valid = 0;
      guard = 0;
      while (!m_ready && guard < 10) begin
        cyc();
        guard++;
      end
      n_chk++;
      if (!m_ready || wt_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL osc_commit[%0d]: ready=%b want 1", it, wt_ready);
      end
      for (int i = 0; i < 30; i++) begin
        sin = 1'($urandom_range(0, 1));
        din = 1'($urandom_range(0, 1));
        cyc();
        n_chk++;
        if (sout !== m_sout || dout !== m_dout || wt_ready !== m_ready) begin
          n_fail++;
          $display("FAIL osc_rand[%0d.%0d] code=%0d: sout=%b dout=%b ready=%b want %b %b %b",
                   it, i, m_act, sout, dout, wt_ready, m_sout, m_dout, m_ready);
        end
      end
    end
  endtask

  task automatic test_commit_hold();
    sin = 1; din = 0;
    repeat (3) cyc();
    wt_valid = 1; wt_data = '0;
    cyc();
    wt_valid = 0;
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (wt_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_ready[%0d]: got %b want 0", i, wt_ready);
      end
      cyc();
    end
    sin = 0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      n_chk++;
      if (wt_ready !== (i == 3) || wt_ready !== m_ready) begin
        n_fail++;
        $display("FAIL release_ready[%0d]: got %b want %b", i, wt_ready, (i == 3));
      end
    end
  endtask

  task automatic test_measure();
    sin = 1; din = 0;
    repeat (3) cyc();
    start = 1; win_len = CW'(10);
    cyc();
    start = 0;
    for (int i = 1; i <= 11; i++) begin
      n_chk++;
      if (busy !== (i <= 10) || done !== (i == 11)) begin
        n_fail++;
        $display("FAIL window10 cycle %0d: busy=%b done=%b want %b %b", i, busy, done, (i <= 10), (i == 11));
      end
      if (i == 11) begin
        n_chk++;
        if (mm_count !== CW'(10)) begin
          n_fail++;
          $display("FAIL window10_count: got %0d want 10", mm_count);
        end
      end
      if (i < 11) cyc();
    end
    cyc();
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0 || mm_count !== CW'(10)) begin
      n_fail++;
      $display("FAIL window10_hold: done=%b busy=%b mm=%0d want 0 0 10", done, busy, mm_count);
    end
  endtask

  task automatic test_zero_and_ignore();
    int seen;
    start = 1; win_len = '0;
    cyc();
    start = 0;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || mm_count !== '0) begin
      n_fail++;
      $display("FAIL zero_win: done=%b busy=%b mm=%0d want 1 0 0", done, busy, mm_count);
    end
    cyc();
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_win_pulse: done=%b want 0", done);
    end
    start = 1; win_len = CW'(8);
    cyc();
    start = 0;
    seen = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin start = 1; win_len = CW'(2); end
      if (i == 4) start = 0;
      if (done === 1'b1 && seen == 0) seen = i;
      cyc();
    end
    n_chk++;
    if (seen != 9 || mm_count !== CW'(8)) begin
      n_fail++;
      $display("FAIL start_ignored: done at cycle %0d mm=%0d want 9 8", seen, mm_count);
    end
  endtask

  task automatic test_random_measure();
    int wl;
    bit seen;
    for (int r = 0; r < 6; r++) begin
      wl = $urandom_range(1, 40);
      start = 1; win_len = CW'(wl);
      cyc();
      start = 0;
      seen = 0;
      for (int i = 0; i < wl + 3; i++) begin
        n_chk++;
        if (busy !== m_busy || done !== m_done) begin
          n_fail++;
          $display("FAIL rand_fsm[%0d.%0d]: busy=%b done=%b want %b %b", r, i, busy, done, m_busy, m_done);
        end
        if (m_done) seen = 1;
        sin = 1'($urandom_range(0, 1));
        din = 1'($urandom_range(0, 1));
        cyc();
      end
      n_chk++;
      if (!seen || mm_count !== CW'(m_mm)) begin
        n_fail++;
        $display("FAIL rand_count[%0d] win=%0d: mm=%0d want %0d", r, wl, mm_count, m_mm);
      end
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    bit late_done;
    sin = 1; din = 0;
    repeat (3) cyc();
    wt_valid = 1; wt_data = WW'(4);
    cyc();
    wt_valid = 0;
    start4 = 1; win_len4 = 4'd15;
    cyc();
    start4 = 0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (done4 === 1'b1 && lat == 0) lat = i;
      if (i < 20) cyc();
    end
    n_chk++;
    if (lat != 16 || mm4 !== 4'd15) begin
      n_fail++;
      $display("FAIL cnt4_full: done at cycle %0d mm=%0d want 16 15", lat, mm4);
    end
    n_chk++;
    if (wt_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_before_rst: ready=%b want 0", wt_ready);
    end
    start4 = 1; win_len4 = 4'd15;
    cyc();
    start4 = 0;
    repeat (4) cyc();
    n_chk++;
    if (busy4 !== 1'b1 || mm4 !== 4'd4) begin
      n_fail++;
      $display("FAIL cnt4_partial: busy=%b mm=%0d want 1 4", busy4, mm4);
    end
    rst = 1;
    cyc();
    rst = 0;
    n_chk++;
    if (mm4 !== 4'd0 || busy4 !== 1'b0 || done4 !== 1'b0 || wt_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_state: mm=%0d busy=%b done=%b ready=%b want 0 0 0 1", mm4, busy4, done4, wt_ready);
    end
    late_done = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (done4 === 1'b1) late_done = 1;
    end
    n_chk++;
    if (late_done || mm4 !== 4'd0) begin
      n_fail++;
      $display("FAIL abort_no_done: done_seen=%b mm=%0d want 0 0", late_done, mm4);
    end
    sin = 0; din = 0;
    repeat (3) cyc();
    sin = 1;
    cyc();
    n_chk++;
    if (sout !== 1'b1 || wt_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL shadow_discard: sout=%b ready=%b want 1 1", sout, wt_ready);
    end
  endtask

  initial begin
    test_reset();
    test_slow();
    test_random_osc();
    test_commit_hold();
    test_measure();
    test_zero_and_ignore();
    test_random_measure();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
